// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, the data width and the latency limit.
package dmem_pkg;

    localparam int DATA_W      = 32;
    localparam int LATENCY_MAX = 15;
    localparam int LAT_CNT_W   = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Storage is deliberately not reset; only the read register is.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata holds the last read word until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder in front of a single-port word RAM.
// Define DMEM_ADDR_CHECK_EN to flag misaligned or out-of-range addresses as errors.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_CNT_W:0] LAT_V = (LAT_CNT_W + 1)'(LATENCY);

    // Handshake: a request is taken on any rising edge in IDLE with mem_read or
    // mem_write high; mem_ready is then a single-cycle strobe qualifying
    // mem_rdata and mem_err, and request inputs are ignored until IDLE again.
    dmem_state_e          state, state_nxt;
    logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
    logic [LAT_CNT_W:0]   cnt_inc;
    logic                 accept;
    logic                 addr_bad;
    logic                 req_read, req_write, req_err;
    logic [AW-1:0]        req_idx;
    logic [DATA_W-1:0]    req_wdata;
    logic                 resp;
    logic                 ram_we, ram_re;

`ifdef DMEM_ADDR_CHECK_EN
    assign addr_bad = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (AW + 2)) != 32'd0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};
    assign addr_bad         = 1'b0;
`endif

    assign accept  = (state == ST_IDLE) && (mem_read || mem_write);
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign resp    = (state == ST_RESP);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_inc == LAT_V) begin
                    state_nxt = ST_RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc[LAT_CNT_W-1:0];
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_err   <= 1'b0;
            req_idx   <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_read  <= mem_read;
            req_write <= mem_write;
            req_err   <= (mem_read && mem_write) || addr_bad;
            req_idx   <= mem_addr[AW+1:2];
            req_wdata <= mem_wdata;
        end
    end

    // RAM access happens on the RESP->IDLE edge, the same edge that raises mem_ready
    assign ram_we = resp && req_write && !req_err;
    assign ram_re = resp && req_read && !req_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_ready <= resp;
            mem_err   <= resp && req_err;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .re   (ram_re),
        .addr (req_idx),
        .wdata(req_wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against an array-based memory model.
// Covers LATENCY=2 transactions, reset abort and LATENCY=0 back-to-back reads.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, mem_err, busy;

    logic        r0_read, r0_write;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r0_ready, r0_err, r0_busy;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata;
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_err  (mem_err),
        .busy     (busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (r0_read),
        .mem_write(r0_write),
        .mem_addr (r0_addr),
        .mem_wdata(r0_wdata),
        .mem_rdata(r0_rdata),
        .mem_ready(r0_ready),
        .mem_err  (r0_err),
        .busy     (r0_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
        return (a % 4 != 0) || (a >= DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        dut.u_array.mem[idx] = val;
        model_mem[idx]       = val;
    endtask

    // One request on the LATENCY=2 instance, checked against the model
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int          idx;
        logic        err;
        logic [31:0] old_word;
        logic [31:0] exp_rdata;
        int          edges;
        logic        seen;
        idx      = int'((addr % (DEPTH * 4)) / 4);
        old_word = model_mem[idx];
        err      = (rd && wr) || addr_bad(addr);
        if (wr && !err) model_mem[idx] = wdata;
        if (rd && !err) last_rdata = model_mem[idx];
        exp_q.push_back(last_rdata);

        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = $urandom; mem_wdata = $urandom;

        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
            else begin
                edges++;
                if (i == LAT) check("no_early_commit", dut.u_array.mem[idx], old_word);
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("ready_latency", edges, LAT + 1);
        exp_rdata = exp_q.pop_front();
        check("rdata", mem_rdata, exp_rdata);
        check("err", 32'(mem_err), 32'(err));
        check("busy_at_resp", 32'(busy), 32'd0);
        check("storage", dut.u_array.mem[idx], model_mem[idx]);
        @(negedge clk);
        check("ready_one_cycle", 32'(mem_ready), 32'd0);
    endtask

    initial begin
        logic rd, wr;
        logic [31:0] a;
        logic pulsed;
        int   sel;

        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
        r0_read = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        dut0.u_array.mem[1] = 32'd10;
        last_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Directed cases
        preload(1, 32'd10);
        do_req(1'b1, 1'b0, 32'h4, 32'h0);
        do_req(1'b0, 1'b1, 32'hC, 32'h5);
        do_req(1'b1, 1'b0, 32'hC, 32'h0);
        preload(2, 32'd7);
        do_req(1'b1, 1'b1, 32'h8, $urandom);
        do_req(1'b0, 1'b1, 32'h6, 32'hDEAD_0006);
        do_req(1'b0, 1'b1, 32'h400, 32'hDEAD_0400);
        do_req(1'b1, 1'b0, 32'h0, 32'h0);

        // Randomized traffic, including misaligned, wrapped and dual requests
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            a   = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
            case ($urandom_range(0, 5))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a + 32'h400 * 32'($urandom_range(1, 4));
                default: ;
            endcase
            do_req(rd, wr, a, $urandom);
        end

        // Reset while a write to 0x10 is waiting: nothing commits or responds
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 32'h10; mem_wdata = ~model_mem[4];
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_err", 32'(mem_err), 32'd0);
        check("abort_rdata", mem_rdata, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        pulsed = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready) pulsed = 1'b1;
        end
        check("abort_no_pulse", 32'(pulsed), 32'd0);
        check("abort_mem4", dut.u_array.mem[4], model_mem[4]);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);

        // LATENCY=0: read held high gives a response every second cycle
        @(negedge clk);
        r0_read = 1'b1; r0_addr = 32'h4;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("l0_ready", 32'(r0_ready), 32'(k % 2 == 0));
            check("l0_busy", 32'(r0_busy), 32'(k % 2 == 1));
            if (k % 2 == 0) begin
                check("l0_rdata", r0_rdata, 32'd10);
                check("l0_err", 32'(r0_err), 32'd0);
            end
        end
        r0_read = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted before each response, range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port mem_read, input, 1: read request from CPU.
REQ-006 SHALL have port mem_write, input, 1: write request from CPU.
REQ-007 SHALL have port mem_addr, input, 32: byte address.
REQ-008 SHALL have port mem_wdata, input, 32: write data.
REQ-009 SHALL have port mem_rdata, output, 32: read data, valid while mem_ready high.
REQ-010 SHALL have port mem_ready, output, 1: one-cycle response strobe.
REQ-011 SHALL have port mem_err, output, 1: error flag, valid while mem_ready high.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept (LATENCY>0), IDLE->RESP on accept (LATENCY=0), WAIT->RESP when latency counter reaches LATENCY, RESP->IDLE unconditionally.
REQ-014 SHALL accept a request only at a rising edge in IDLE with mem_read or mem_write high, registering address, data and request type at that edge.
REQ-015 SHALL ignore mem_read, mem_write, mem_addr and mem_wdata in WAIT and RESP.
REQ-016 SHALL, for a request accepted at edge N, assert mem_ready from edge N+1+LATENCY for exactly one cycle.
REQ-017 SHALL commit a write to storage on the edge that raises mem_ready, never earlier.
REQ-018 SHALL drive mem_rdata with the addressed word for reads and hold it until the next read response; writes leave mem_rdata unchanged.
REQ-019 SHALL index storage by word, addr[log2(DEPTH_WORDS)+1:2].
REQ-020 SHALL treat mem_read and mem_write both high at accept as an error: no write, mem_rdata unchanged, mem_err=1.
REQ-021 SHALL accept a request still held high when returning to IDLE as a new request (back-to-back spacing LATENCY+2 cycles).
REQ-022 SHALL deassert mem_err on every response not flagged as error.

Reset
REQ-023 SHALL, while rst_n low, force state IDLE, latency counter 0, mem_rdata 0, mem_ready 0, mem_err 0, busy 0.
REQ-024 SHALL NOT reset storage contents.
REQ-025 SHALL discard a pending write when reset asserts in WAIT or RESP before the commit edge.

Configuration
REQ-026 SHALL, with DMEM_ADDR_CHECK_EN defined, flag mem_err=1 and suppress the write for addr[1:0]!=0 or addr>=DEPTH_WORDS*4, returning mem_rdata unchanged.
REQ-027 SHALL, without DMEM_ADDR_CHECK_EN, tie mem_err to 0 except the REQ-020 case, ignore addr[1:0] and wrap addresses modulo DEPTH_WORDS*4.

Structure
REQ-028 SHALL take the state enum type, data width 32 and the LATENCY maximum constant from shared package dmem_pkg.
REQ-029 SHALL instantiate one sub-module dmem_array: single-port synchronous RAM, 32-bit words, DEPTH_WORDS deep, storage array named mem for bench back-door preload.

Verification (LATENCY=2, DEPTH_WORDS=256 unless stated)
REQ-030 SHALL cover: preload mem[1]=10, read 0x4 accepted at edge N -> mem_ready at edge N+3 for one cycle, mem_rdata=10, mem_err=0.
REQ-031 SHALL cover: write 0x0000_0005 to 0xC, then read 0xC -> mem[3]=5 only after the write's mem_ready edge, read returns 5.
REQ-032 SHALL cover: mem_read and mem_write both high, addr 0x8, mem[2]=7 -> mem_err=1, mem[2] stays 7.
REQ-033 SHALL cover with DMEM_ADDR_CHECK_EN: write to 0x6 and to 0x400 -> mem_err=1, no storage change; without macro write to 0x400 updates mem[0].
REQ-034 SHALL cover: rst_n low one cycle after write to 0x10 accepted -> mem[4] unchanged, mem_ready never pulses, all outputs 0.
REQ-035 SHALL cover: LATENCY=0, mem_read held high continuously -> mem_ready pulses every 2 cycles, busy toggles accordingly.
